// File: rtl/riscv_pkg.sv
// Shared encodings for the pipelined RISC-V core: writeback source select,
// load/store funct3 codes and the LSU handshake state.
package riscv_pkg;

    // Writeback mux select (resultSrc)
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;
    localparam logic [1:0] RESULT_IMM = 2'b11;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    // An instruction touches data memory if it stores or writes back load data.
    function automatic logic isMemOp(input logic memWrite, input logic [1:0] resultSrc);
        return memWrite | (resultSrc == RESULT_MEM);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the LSU: store byte enables and data replication,
// load lane extraction with sign/zero extension, and misalignment / illegal
// funct3 detection.
module load_store_align
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic              isStore,
    input  logic [1:0]        addrLo,
    input  logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    output logic [3:0]        byteEn,
    output logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] loadData,
    output logic              misaligned,
    output logic              illegal
);

    logic [DATA_W-1:0] laneData;

    // Byte enables, store replication and access legality
    always_comb begin
        byteEn     = 4'b1111;
        wData      = writeData;
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (isStore) begin
            case (funct3)
                F3_SB: begin
                    byteEn = 4'b0001 << addrLo;
                    wData  = {4{writeData[7:0]}};
                end
                F3_SH: begin
                    byteEn     = 4'b0011 << addrLo;
                    wData      = {2{writeData[15:0]}};
                    misaligned = addrLo[0];
                end
                F3_SW: begin
                    misaligned = |addrLo;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: misaligned = 1'b0;
                F3_LH, F3_LHU: misaligned = addrLo[0];
                F3_LW:         misaligned = |addrLo;
                default:       illegal    = 1'b1;
            endcase
        end
    end

    // Shift the addressed lane down to bit 0, then extend by access type
    always_comb begin
        laneData = readData >> {addrLo, 3'b000};
        case (funct3)
            F3_LB:   loadData = {{(DATA_W-8){laneData[7]}}, laneData[7:0]};
            F3_LH:   loadData = {{(DATA_W-16){laneData[15]}}, laneData[15:0]};
            F3_LBU:  loadData = {{(DATA_W-8){1'b0}}, laneData[7:0]};
            F3_LHU:  loadData = {{(DATA_W-16){1'b0}}, laneData[15:0]};
            default: loadData = readData;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage pipeline: drives the data memory over a req/ready
// handshake, stalls the front of the pipe while an access is outstanding, times
// out a silent memory, and holds the MEM/WB pipeline register.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    // EX/MEM register
    input  logic              regWriteM,
    input  logic [1:0]        resultSrcM,
    input  logic              memWriteM,
    input  logic [2:0]        funct3M,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] writeDataM,
    input  logic [4:0]        RDM,
    input  logic [DATA_W-1:0] immExtM,
    input  logic [DATA_W-1:0] PCPlus4M,
    // Hazard control
    output logic              stallM,
    // Data memory
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [DATA_W-1:0] dmemAddr,
    output logic [DATA_W-1:0] dmemWData,
    output logic [3:0]        dmemByteEn,
    input  logic [DATA_W-1:0] dmemRData,
    input  logic              dmemReady,
    output logic              memErr,
    // MEM/WB register
    output logic              regWriteW,
    output logic [1:0]        resultSrcW,
    output logic [DATA_W-1:0] ALUResultW,
    output logic [DATA_W-1:0] readDataW,
    output logic [4:0]        RDW,
    output logic [DATA_W-1:0] immExtW,
    output logic [DATA_W-1:0] PCPlus4W
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    lsu_state_t        stateQ, stateD;
    logic [WaitW-1:0]  waitCntQ;

    logic              memOp;
    logic              accessErr;
    logic              accept;
    logic              done;
    logic              timeout;
    logic              bubble;

    logic [3:0]        alignByteEn;
    logic [DATA_W-1:0] alignWData;
    logic [DATA_W-1:0] loadData;
    logic              misaligned;
    logic              illegal;

    // M inputs are held stable by stallM, so the same decode serves both the
    // request issue in IDLE and the load extraction on completion in BUSY.
    load_store_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .funct3     (funct3M),
        .isStore    (memWriteM),
        .addrLo     (ALUResultM[1:0]),
        .writeData  (writeDataM),
        .readData   (dmemRData),
        .byteEn     (alignByteEn),
        .wData      (alignWData),
        .loadData   (loadData),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign memOp     = isMemOp(memWriteM, resultSrcM);
    assign accessErr = misaligned | illegal;
    assign accept    = (stateQ == IDLE) & memOp & ~accessErr;
    assign done      = (stateQ == BUSY) & dmemReady;
    assign timeout   = (stateQ == BUSY) & ~dmemReady & (waitCntQ == WaitLast);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next state: accepted access goes BUSY until ready or timeout
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (accept) stateD = BUSY;
            BUSY:    if (done || timeout) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // FSM outputs: request, stall and error pulse
    always_comb begin
        dmemReq = 1'b0;
        stallM  = 1'b0;
        memErr  = 1'b0;
        if (!rst) begin
            case (stateQ)
                IDLE: begin
                    stallM = accept;
                    memErr = memOp & accessErr;
                end
                BUSY: begin
                    dmemReq = 1'b1;
                    // Release the pipe in the completing cycle so EX/MEM advances
                    stallM  = ~dmemReady & ~timeout;
                    memErr  = timeout;
                end
                default: ;
            endcase
        end
    end

    // Cycles spent in BUSY without a ready
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCntQ <= '0;
        end else if (stateQ == IDLE || timeout) begin
            waitCntQ <= '0;
        end else if (!dmemReady) begin
            waitCntQ <= waitCntQ + WaitW'(1);
        end
    end

    // Memory request fields, captured on accept and held stable through BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            dmemWe     <= 1'b0;
            dmemAddr   <= '0;
            dmemWData  <= '0;
            dmemByteEn <= 4'b0000;
        end else if (accept) begin
            dmemWe     <= memWriteM;
            dmemAddr   <= {ALUResultM[DATA_W-1:2], 2'b00};
            dmemWData  <= alignWData;
            dmemByteEn <= memWriteM ? alignByteEn : 4'b1111;
        end
    end

    // A stalled or faulted instruction must not reach writeback
    assign bubble = stallM | memErr;

    // MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            regWriteW  <= 1'b0;
            resultSrcW <= 2'b00;
            ALUResultW <= '0;
            readDataW  <= '0;
            RDW        <= 5'd0;
            immExtW    <= '0;
            PCPlus4W   <= '0;
        end else begin
            resultSrcW <= resultSrcM;
            ALUResultW <= ALUResultM;
            readDataW  <= loadData;
            immExtW    <= immExtM;
            PCPlus4W   <= PCPlus4M;
            regWriteW  <= bubble ? 1'b0 : regWriteM;
            RDW        <= bubble ? 5'd0 : RDM;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a scoreboard queue of expected MEM/WB
// contents is filled as each instruction is presented and drained when the
// stage hands the instruction (or its bubble) to writeback.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteM;
    logic [1:0]  resultSrcM;
    logic        memWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] writeDataM;
    logic [4:0]  RDM;
    logic [31:0] immExtM;
    logic [31:0] PCPlus4M;
    logic        stallM;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWData;
    logic [3:0]  dmemByteEn;
    logic [31:0] dmemRData;
    logic        dmemReady;
    logic        memErr;
    logic        regWriteW;
    logic [1:0]  resultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] readDataW;
    logic [4:0]  RDW;
    logic [31:0] immExtW;
    logic [31:0] PCPlus4W;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        regWrite;
        logic [4:0]  rd;
        logic        chkData;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic        chkRead;
        logic [31:0] readData;
    } wbExp_t;

    wbExp_t sb[$];

    mem_stage_lsu #(
        .DATA_W   (32),
        .MAX_WAIT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .regWriteM  (regWriteM),
        .resultSrcM (resultSrcM),
        .memWriteM  (memWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .writeDataM (writeDataM),
        .RDM        (RDM),
        .immExtM    (immExtM),
        .PCPlus4M   (PCPlus4M),
        .stallM     (stallM),
        .dmemReq    (dmemReq),
        .dmemWe     (dmemWe),
        .dmemAddr   (dmemAddr),
        .dmemWData  (dmemWData),
        .dmemByteEn (dmemByteEn),
        .dmemRData  (dmemRData),
        .dmemReady  (dmemReady),
        .memErr     (memErr),
        .regWriteW  (regWriteW),
        .resultSrcW (resultSrcW),
        .ALUResultW (ALUResultW),
        .readDataW  (readDataW),
        .RDW        (RDW),
        .immExtW    (immExtW),
        .PCPlus4W   (PCPlus4W)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setM(input logic rw, input logic [1:0] src, input logic mw,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc4);
        regWriteM  = rw;
        resultSrcM = src;
        memWriteM  = mw;
        funct3M    = f3;
        ALUResultM = alu;
        writeDataM = wd;
        RDM        = rd;
        immExtM    = imm;
        PCPlus4M   = pc4;
    endtask

    task automatic setNop();
        setM(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic pushExp(input string tag, input logic rw, input logic [4:0] rd,
                           input logic chkData, input logic [31:0] alu, input logic [31:0] imm,
                           input logic [31:0] pc4, input logic chkRead,
                           input logic [31:0] readData);
        wbExp_t e;
        e.tag      = tag;
        e.regWrite = rw;
        e.rd       = rd;
        e.chkData  = chkData;
        e.alu      = alu;
        e.imm      = imm;
        e.pc4      = pc4;
        e.chkRead  = chkRead;
        e.readData = readData;
        sb.push_back(e);
    endtask

    // Compare the MEM/WB register against the oldest expected entry
    task automatic popCheck();
        wbExp_t e;
        if (sb.size() == 0) begin
            checkVal("sb.empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkVal({e.tag, ".regWriteW"}, regWriteW, e.regWrite);
            checkVal({e.tag, ".RDW"}, RDW, e.rd);
            if (e.chkData) begin
                checkVal({e.tag, ".ALUResultW"}, ALUResultW, e.alu);
                checkVal({e.tag, ".immExtW"}, immExtW, e.imm);
                checkVal({e.tag, ".PCPlus4W"}, PCPlus4W, e.pc4);
            end
            if (e.chkRead) checkVal({e.tag, ".readDataW"}, readDataW, e.readData);
        end
    endtask

    // Non-memory op: one-cycle pass-through, no stall, dmemReady ignored in IDLE
    task automatic aluOp(input string tag, input logic [1:0] src, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [31:0] imm, input logic readyIdle);
        setM(1'b1, src, 1'b0, 3'b010, alu, 32'hDEAD_0000, rd, imm, alu + 32'd4);
        dmemReady = readyIdle;
        #1;
        checkVal({tag, ".stallM"}, stallM, 1'b0);
        checkVal({tag, ".dmemReq"}, dmemReq, 1'b0);
        pushExp(tag, 1'b1, rd, 1'b1, alu, imm, alu + 32'd4, 1'b0, 32'h0);
        step();
        dmemReady = 1'b0;
        setNop();
        popCheck();
    endtask

    // Legal load/store; ready arrives after waitN BUSY cycles without it
    task automatic memAccess(input string tag, input logic isStore, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input logic [4:0] rd, input int waitN,
                             input logic [31:0] expRead, input logic [3:0] expBe,
                             input logic [31:0] expWData);
        int stallCnt = 0;
        setM(~isStore, isStore ? 2'b00 : 2'b01, isStore, f3, addr, wd, rd, 32'h0000_0011,
             addr + 32'd4);
        dmemRData = rdata;
        dmemReady = 1'b0;
        #1;
        checkVal({tag, ".idleReq"}, dmemReq, 1'b0);
        if (stallM) stallCnt++;
        pushExp(tag, ~isStore, rd, 1'b1, addr, 32'h0000_0011, addr + 32'd4, ~isStore, expRead);
        step();
        for (int c = 0; c <= waitN; c++) begin
            dmemReady = (c == waitN);
            #1;
            if (c == 0) begin
                checkVal({tag, ".dmemReq"}, dmemReq, 1'b1);
                checkVal({tag, ".dmemAddr"}, dmemAddr, {addr[31:2], 2'b00});
                checkVal({tag, ".dmemWe"}, dmemWe, isStore);
                checkVal({tag, ".dmemByteEn"}, dmemByteEn, expBe);
                if (isStore) checkVal({tag, ".dmemWData"}, dmemWData, expWData);
            end
            if (stallM) stallCnt++;
            step();
        end
        dmemReady = 1'b0;
        setNop();
        #1;
        popCheck();
        checkVal({tag, ".stallCycles"}, stallCnt, waitN + 1);
        checkVal({tag, ".reqAfter"}, dmemReq, 1'b0);
    endtask

    // Misaligned or illegal access: error pulse, no request, no stall, bubble
    task automatic errOp(input string tag, input logic isStore, input logic [2:0] f3,
                         input logic [31:0] addr);
        setM(~isStore, isStore ? 2'b00 : 2'b01, isStore, f3, addr, 32'h1234_5678, 5'd9,
             32'h0, 32'h0);
        dmemReady = 1'b0;
        #1;
        checkVal({tag, ".memErr"}, memErr, 1'b1);
        checkVal({tag, ".stallM"}, stallM, 1'b0);
        checkVal({tag, ".dmemReq"}, dmemReq, 1'b0);
        pushExp(tag, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        setNop();
        #1;
        popCheck();
        checkVal({tag, ".memErrAfter"}, memErr, 1'b0);
        checkVal({tag, ".reqAfter"}, dmemReq, 1'b0);
    endtask

    initial begin
        int busyCnt;
        logic errSeen;

        rst       = 1'b1;
        dmemReady = 1'b0;
        dmemRData = 32'h0;
        setM(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 32'h0, 32'h0);
        step();
        step();
        checkVal("reset.dmemReq", dmemReq, 1'b0);
        checkVal("reset.stallM", stallM, 1'b0);
        checkVal("reset.memErr", memErr, 1'b0);
        checkVal("reset.regWriteW", regWriteW, 1'b0);
        checkVal("reset.ALUResultW", ALUResultW, 32'h0);
        checkVal("reset.dmemAddr", dmemAddr, 32'h0);
        setNop();
        rst = 1'b0;
        step();

        aluOp("alu", 2'b00, 32'h0000_1234, 5'd5, 32'h0000_00AA, 1'b0);
        aluOp("aluReadyIdle", 2'b10, 32'h0000_4000, 5'd31, 32'hFFFF_F000, 1'b1);

        memAccess("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 5'd6, 2,
                  32'hFFFF_FF80, 4'b1111, 32'h0);
        memAccess("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 5'd7, 2,
                  32'h0000_0080, 4'b1111, 32'h0);
        memAccess("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_FF7F, 5'd8, 1,
                  32'hFFFF_80FF, 4'b1111, 32'h0);
        memAccess("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_FF7F, 5'd9, 0,
                  32'h0000_80FF, 4'b1111, 32'h0);
        memAccess("lbPos", 1'b0, 3'b000, 32'h100, 32'h0, 32'h80FF_FF7F, 5'd10, 0,
                  32'h0000_007F, 4'b1111, 32'h0);
        memAccess("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF_FF7F, 5'd11, 3,
                  32'h80FF_FF7F, 4'b1111, 32'h0);
        memAccess("sh", 1'b1, 3'b001, 32'h202, 32'hCAFE_BEEF, 32'h0, 5'd0, 1,
                  32'h0, 4'b1100, 32'hBEEF_BEEF);
        memAccess("sb", 1'b1, 3'b000, 32'h301, 32'h0000_00A5, 32'h0, 5'd0, 0,
                  32'h0, 4'b0010, 32'hA5A5_A5A5);
        memAccess("sw", 1'b1, 3'b010, 32'h204, 32'hCAFE_BEEF, 32'h0, 5'd0, 2,
                  32'h0, 4'b1111, 32'hCAFE_BEEF);

        errOp("lwMisalign", 1'b0, 3'b010, 32'h201);
        errOp("lhMisalign", 1'b0, 3'b001, 32'h101);
        errOp("swMisalign", 1'b1, 3'b010, 32'h206);
        errOp("ldIllegal", 1'b0, 3'b011, 32'h100);
        errOp("stIllegal", 1'b1, 3'b100, 32'h100);

        // Timeout: memory never answers
        setM(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd12, 32'h0, 32'h104);
        dmemReady = 1'b0;
        pushExp("timeout", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        busyCnt = 0;
        errSeen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmemReq) busyCnt++;
            if (memErr) begin
                errSeen = 1'b1;
                checkVal("timeout.stallM", stallM, 1'b0);
            end
            step();
            if (errSeen) break;
        end
        setNop();
        #1;
        checkVal("timeout.seen", errSeen, 1'b1);
        checkVal("timeout.busyCycles", busyCnt, 32'd15);
        checkVal("timeout.reqAfter", dmemReq, 1'b0);
        checkVal("timeout.memErrAfter", memErr, 1'b0);
        popCheck();

        // Normal access still works after a timeout
        memAccess("lwAfterTo", 1'b0, 3'b010, 32'h108, 32'h0, 32'h0102_0304, 5'd13, 1,
                  32'h0102_0304, 4'b1111, 32'h0);

        // Reset while BUSY aborts the access
        setM(1'b1, 2'b01, 1'b0, 3'b010, 32'h104, 32'h0, 5'd7, 32'h5, 32'h108);
        step();
        checkVal("rstBusy.reqBefore", dmemReq, 1'b1);
        rst = 1'b1;
        step();
        checkVal("rstBusy.dmemReq", dmemReq, 1'b0);
        checkVal("rstBusy.stallM", stallM, 1'b0);
        checkVal("rstBusy.ALUResultW", ALUResultW, 32'h0);
        checkVal("rstBusy.PCPlus4W", PCPlus4W, 32'h0);
        checkVal("rstBusy.regWriteW", regWriteW, 1'b0);
        setNop();
        rst = 1'b0;
        step();
        checkVal("rstBusy.idleReq", dmemReq, 1'b0);
        checkVal("rstBusy.idleStall", stallM, 1'b0);
        checkVal("sb.drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
